// File: rtl/csi_pkg.sv
// Shared types and default widths for the CSI extraction path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csi_pkg;

    localparam int MAG_SQ_WIDTH        = 32;
    localparam int DEFAULT_WINDOW_LOG2 = 4;

    // Explicit encodings so the 2-bit state register has a fixed layout.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } energy_det_state_t;

endpackage : csi_pkg

// File: rtl/mag_sq_window_buffer.sv
// Circular buffer holding the last 2^WINDOW_LOG2 accepted samples, with fill tracking.
// Latency: write lands on the next edge; oldest_out is combinational from the current wr_ptr.
// Backpressure: none, one write per cycle when wr_en_in is high.
// Ports: clk_in/rst_n_in clock and async reset; clear_in flush; wr_en_in/wr_dat_in sample write;
//        oldest_out entry about to be overwritten; full_out window holds W samples;
//        fill_last_out next write completes the window.
module mag_sq_window_buffer
    import csi_pkg::*;
#(
    parameter int DATA_WIDTH  = MAG_SQ_WIDTH,
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  clear_in,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] wr_dat_in,
    output logic [DATA_WIDTH-1:0] oldest_out,
    output logic                  full_out,
    output logic                  fill_last_out
);

    localparam int W = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [WINDOW_LOG2:0]   CNT_ONE  = 1;
    localparam logic [WINDOW_LOG2:0]   CNT_FULL = (WINDOW_LOG2+1)'(W);

    logic [DATA_WIDTH-1:0]  mem [W];
    logic [WINDOW_LOG2-1:0] wr_ptr;
    logic [WINDOW_LOG2:0]   fill_cnt;

    // The slot at wr_ptr is both the oldest sample and the next one replaced.
    assign oldest_out    = mem[wr_ptr];
    assign full_out      = (fill_cnt == CNT_FULL);
    assign fill_last_out = (fill_cnt == CNT_FULL - CNT_ONE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < W; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (clear_in) begin
            // Zeroed slots let the running sum subtract them harmlessly during refill.
            for (int i = 0; i < W; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (wr_en_in) begin
            mem[wr_ptr] <= wr_dat_in;
            wr_ptr      <= wr_ptr + PTR_ONE;
            if (!full_out) fill_cnt <= fill_cnt + CNT_ONE;
        end
    end

endmodule : mag_sq_window_buffer

// File: rtl/mag_sq_energy_detector.sv
// Sliding-window energy sum over squared magnitudes with hysteresis detect FSM.
// Latency: 1 cycle from accepted sample to energy/valid/detect/pulse outputs.
// Backpressure: none, accepts one sample every cycle.
// Ports: clk_in/rst_n_in clock and async reset; mag_sq_in/mag_sq_valid_in sample stream;
//        clear_in synchronous flush; threshold_on_in/threshold_off_in hysteresis levels;
//        energy_out/energy_valid_out window sum and strobe; detect_out/_start_out/_end_out detect flag and edges.
module mag_sq_energy_detector
    import csi_pkg::*;
#(
    parameter  int DATA_WIDTH  = MAG_SQ_WIDTH,
    parameter  int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    localparam int SUM_WIDTH   = DATA_WIDTH + WINDOW_LOG2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] mag_sq_in,
    input  logic                  mag_sq_valid_in,
    input  logic                  clear_in,
    input  logic [SUM_WIDTH-1:0]  threshold_on_in,
    input  logic [SUM_WIDTH-1:0]  threshold_off_in,
    output logic [SUM_WIDTH-1:0]  energy_out,
    output logic                  energy_valid_out,
    output logic                  detect_out,
    output logic                  detect_start_out,
    output logic                  detect_end_out
);

    energy_det_state_t     state;
    logic [SUM_WIDTH-1:0]  sum_q;
    logic [SUM_WIDTH-1:0]  next_sum;
    logic [DATA_WIDTH-1:0] oldest;
    logic                  accept;
    logic                  full;
    logic                  fill_last;
    logic                  fill_done;

    assign accept = mag_sq_valid_in && !clear_in;

    mag_sq_window_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .clear_in      (clear_in),
        .wr_en_in      (accept),
        .wr_dat_in     (mag_sq_in),
        .oldest_out    (oldest),
        .full_out      (full),
        .fill_last_out (fill_last)
    );

    // The evicted sample is always already inside sum_q, so this cannot underflow,
    // and SUM_WIDTH carries W full-scale samples, so it cannot overflow either.
    assign next_sum  = sum_q + SUM_WIDTH'(mag_sq_in) - SUM_WIDTH'(oldest);
    assign fill_done = !full && fill_last;

    assign energy_out = sum_q;
    assign detect_out = (state == ACTIVE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= FILL;
            sum_q            <= '0;
            energy_valid_out <= 1'b0;
            detect_start_out <= 1'b0;
            detect_end_out   <= 1'b0;
        end else begin
            energy_valid_out <= 1'b0;
            detect_start_out <= 1'b0;
            detect_end_out   <= 1'b0;
            if (clear_in) begin
                sum_q          <= '0;
                state          <= FILL;
                detect_end_out <= (state == ACTIVE);
            end else if (accept) begin
                sum_q            <= next_sum;
                energy_valid_out <= 1'b1;
                unique case (state)
                    FILL: begin
                        // The completing sample is also the first detect decision.
                        if (fill_done) begin
                            if (next_sum >= threshold_on_in) begin
                                state            <= ACTIVE;
                                detect_start_out <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    IDLE: begin
                        if (next_sum >= threshold_on_in) begin
                            state            <= ACTIVE;
                            detect_start_out <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (next_sum < threshold_off_in) begin
                            state          <= IDLE;
                            detect_end_out <= 1'b1;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule : mag_sq_energy_detector

// File: tb/tb_mag_sq_energy_detector.sv
// Self-checking bench for mag_sq_energy_detector with a queue-based window model.
// Latency: checks every output one cycle after each driven input set.
// Backpressure: n/a (stimulus only).
module tb_mag_sq_energy_detector;

    localparam int DW = 32;
    localparam int WL = 4;
    localparam int SW = DW + WL;
    localparam int W  = 1 << WL;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [DW-1:0] mag_sq_in;
    logic          mag_sq_valid_in;
    logic          clear_in;
    logic [SW-1:0] threshold_on_in;
    logic [SW-1:0] threshold_off_in;
    logic [SW-1:0] energy_out;
    logic          energy_valid_out;
    logic          detect_out;
    logic          detect_start_out;
    logic          detect_end_out;

    mag_sq_energy_detector #(.DATA_WIDTH(DW), .WINDOW_LOG2(WL)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .mag_sq_in        (mag_sq_in),
        .mag_sq_valid_in  (mag_sq_valid_in),
        .clear_in         (clear_in),
        .threshold_on_in  (threshold_on_in),
        .threshold_off_in (threshold_off_in),
        .energy_out       (energy_out),
        .energy_valid_out (energy_valid_out),
        .detect_out       (detect_out),
        .detect_start_out (detect_start_out),
        .detect_end_out   (detect_end_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the window is literally the list of the last W accepted samples.
    logic [DW-1:0] win[$];
    int            m_count;
    bit            m_det;
    logic [SW-1:0] m_energy;
    bit            e_vld, e_start, e_end;

    typedef struct {
        bit            valid;
        bit            clear;
        logic [DW-1:0] mag;
        logic [SW-1:0] exp_energy;
        bit            exp_vld;
        bit            exp_det;
        bit            exp_start;
        bit            exp_end;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_count  = 0;
        m_det    = 1'b0;
        m_energy = '0;
        e_vld = 0; e_start = 0; e_end = 0;
    endtask

    task automatic model_step(input bit v, input bit c, input logic [DW-1:0] m);
        logic [SW-1:0] s;
        e_vld = 0; e_start = 0; e_end = 0;
        if (c) begin
            e_end    = m_det;
            m_det    = 1'b0;
            win.delete();
            m_count  = 0;
            m_energy = '0;
        end else if (v) begin
            win.push_back(m);
            if (win.size() > W) void'(win.pop_front());
            s = '0;
            foreach (win[i]) s += SW'(win[i]);
            m_energy = s;
            e_vld    = 1;
            if (m_count < W) m_count++;
            // Decisions start with the sample that makes the window complete.
            if (m_count == W) begin
                if (!m_det && s >= threshold_on_in) begin
                    m_det = 1'b1; e_start = 1;
                end else if (m_det && s < threshold_off_in) begin
                    m_det = 1'b0; e_end = 1;
                end
            end
        end
    endtask

    // Called at a falling edge; drives inputs, advances one cycle, checks against the model.
    task automatic step(input bit v, input bit c, input logic [DW-1:0] m);
        mag_sq_valid_in = v;
        clear_in        = c;
        mag_sq_in       = m;
        model_step(v, c, m);
        @(negedge clk_in);
        check("energy",       64'(energy_out),       64'(m_energy));
        check("energy_valid", 64'(energy_valid_out), 64'(e_vld));
        check("detect",       64'(detect_out),       64'(m_det));
        check("detect_start", 64'(detect_start_out), 64'(e_start));
        check("detect_end",   64'(detect_end_out),   64'(e_end));
    endtask

    task automatic apply_vec(input vec_t vv);
        mag_sq_valid_in = vv.valid;
        clear_in        = vv.clear;
        mag_sq_in       = vv.mag;
        model_step(vv.valid, vv.clear, vv.mag);
        @(negedge clk_in);
        check("vec_energy", 64'(energy_out),       64'(vv.exp_energy));
        check("vec_vld",    64'(energy_valid_out), 64'(vv.exp_vld));
        check("vec_det",    64'(detect_out),       64'(vv.exp_det));
        check("vec_start",  64'(detect_start_out), 64'(vv.exp_start));
        check("vec_end",    64'(detect_end_out),   64'(vv.exp_end));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_energy"}, 64'(energy_out),       64'd0);
        check({tag, "_vld"},    64'(energy_valid_out), 64'd0);
        check({tag, "_det"},    64'(detect_out),       64'd0);
        check({tag, "_start"},  64'(detect_start_out), 64'd0);
        check({tag, "_end"},    64'(detect_end_out),   64'd0);
    endtask

    initial begin
        int n_start, n_end, start_idx, end_idx;

        rst_n_in = 1'b0; mag_sq_in = '0; mag_sq_valid_in = 1'b0; clear_in = 1'b0;
        threshold_on_in = SW'(1000); threshold_off_in = SW'(500);
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Fill with 10s, one idle gap after the 8th sample; no detect or pulse in fill.
        for (int i = 0; i < W; i++) begin
            vec_t v;
            v = '{1'b1, 1'b0, 32'd10, SW'(10 * (i + 1)), 1'b1, 1'b0, 1'b0, 1'b0};
            vecs.push_back(v);
            if (i == 7) begin
                v = '{1'b0, 1'b0, 32'd0, SW'(80), 1'b0, 1'b0, 1'b0, 1'b0};
                vecs.push_back(v);
            end
        end
        foreach (vecs[i]) apply_vec(vecs[i]);

        // Hysteresis: window starts at 16x10=160. 100s add 90 each -> 1060 at the 10th.
        // 40s end at 640 (stays active); 20s drop 20 each -> 480 at the 8th.
        n_start = 0; n_end = 0; start_idx = -1; end_idx = -1;
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'b0, (i < 16) ? 32'd100 : (i < 32) ? 32'd40 : 32'd20);
            if (detect_start_out === 1'b1) begin n_start++; start_idx = i; end
            if (detect_end_out === 1'b1)   begin n_end++;   end_idx = i;   end
        end
        check("hyst_start_count", 64'(n_start), 64'd1);
        check("hyst_end_count",   64'(n_end),   64'd1);
        check("hyst_start_index", 64'(start_idx), 64'd9);
        check("hyst_end_index",   64'(end_idx),   64'd39);
        check("hyst_final_sum",   64'(energy_out), 64'd320);

        // Random gaps and wrap-around against the queue model.
        threshold_on_in = SW'(8000); threshold_off_in = SW'(6000);
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 3) != 0, 1'b0, 32'($urandom_range(0, 1000)));

        // Clear, then 16x100 completes fill straight into ACTIVE.
        threshold_on_in = SW'(1000); threshold_off_in = SW'(500);
        step(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 32'd100);
        check("fill_to_active", 64'(detect_out), 64'd1);

        // Clear with valid high while ACTIVE: sample dropped, end pulse, zero energy.
        step(1'b1, 1'b1, 32'd999);
        check("clr_end",    64'(detect_end_out),   64'd1);
        check("clr_det",    64'(detect_out),       64'd0);
        check("clr_energy", 64'(energy_out),       64'd0);
        check("clr_vld",    64'(energy_valid_out), 64'd0);
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 32'd7);
        check("refill_sum", 64'(energy_out), 64'd112);

        // Async reset between edges while ACTIVE.
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 32'd200);
        mag_sq_valid_in = 1'b1; mag_sq_in = 32'd5;
        #2 rst_n_in = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        threshold_on_in = SW'(1); threshold_off_in = SW'(1);
        for (int i = 0; i < W - 1; i++) step(1'b1, 1'b0, 32'd50);
        check("rst_no_early_detect", 64'(detect_out), 64'd0);
        step(1'b1, 1'b0, 32'd50);
        check("rst_detect_after_fill", 64'(detect_start_out), 64'd1);

        // Full-scale samples must not wrap.
        step(1'b0, 1'b1, 32'd0);
        threshold_on_in = '1; threshold_off_in = '0;
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 32'hFFFF_FFFF);
        check("max_energy", 64'(energy_out), 64'hF_FFFF_FFF0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        check("max_energy_hold", 64'(energy_out), 64'hF_FFFF_FFF0);
        step(1'b0, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mag_sq_energy_detector
